// File: rtl/cpu_pkg.sv
// cpu_pkg: ISA opcode constants, ALU opcode and control sequencer state encoding.
package cpu_pkg;
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] ALU_ADD = 5'd3;
    typedef enum logic [3:0] {
        RESET_S, F0, F1, F2, DEC, IN0, OUT0, A0, A1, A2, LDI2, LD3, LD4, ST3, ST4, HALT_S
    } state_t;
endpackage

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit sequencing fetch and execute
// of ld/ldi/st/in/out/nop/halt for the System datapath.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] ir,
    output logic                  PCout,
    output logic                  Zlo_out,
    output logic                  MDRout,
    output logic                  Cout,
    output logic                  BAout,
    output logic                  Rout,
    output logic                  MARin,
    output logic                  Zin,
    output logic                  PCin,
    output logic                  MDRin,
    output logic                  IRin,
    output logic                  Yin,
    output logic                  Rin,
    output logic                  Gra,
    output logic                  Grb,
    output logic                  IncPC,
    output logic [4:0]            opcode,
    output logic                  Mem_Read,
    output logic                  Mem_Write,
    output logic                  Mem_enable512x32,
    output logic                  inport_data_ready,
    output logic                  outport_in,
    output logic                  run,
    output logic                  illegal
);
    state_t     r_state, w_next;
    logic [4:0] r_op;
    logic       r_illegal;
    logic [4:0] w_ir_op;
    logic       w_legal;
    logic       w_unused;

    assign w_ir_op  = ir[DATA_WIDTH-1 -: 5];
    assign w_unused = ^ir[DATA_WIDTH-6:0];
    assign w_legal  = w_ir_op inside {OP_LD, OP_LDI, OP_ST, OP_IN, OP_OUT, OP_NOP, OP_HALT};

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            r_state   <= RESET_S;
            r_op      <= OP_NOP;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DEC) begin
                r_op <= w_ir_op;
                if (!w_legal)
                    r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RESET_S: w_next = F0;
            F0:      w_next = F1;
            F1:      w_next = F2;
            F2:      w_next = DEC;
            DEC: begin
                case (w_ir_op)
                    OP_LD, OP_LDI, OP_ST: w_next = A0;
                    OP_IN:                w_next = IN0;
                    OP_OUT:               w_next = OUT0;
                    OP_NOP:               w_next = F0;
                    default:              w_next = HALT_S;
                endcase
            end
            A0:      w_next = A1;
            A1:      w_next = (r_op == OP_LDI) ? LDI2 : A2;
            A2:      w_next = (r_op == OP_LD) ? LD3 : ST3;
            LD3:     w_next = LD4;
            ST3:     w_next = ST4;
            HALT_S:  w_next = HALT_S;
            default: w_next = F0;
        endcase
    end

    always_comb begin
        PCout = 1'b0; Zlo_out = 1'b0; MDRout = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; Rin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; IncPC = 1'b0; opcode = ALU_ADD;
        Mem_Read = 1'b0; Mem_Write = 1'b0; Mem_enable512x32 = 1'b0;
        inport_data_ready = 1'b0; outport_in = 1'b0;
        run = (r_state != RESET_S) && (r_state != HALT_S);
        illegal = r_illegal;
        case (r_state)
            F0:   begin PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1; end
            F1:   begin Zlo_out = 1'b1; PCin = 1'b1; MDRin = 1'b1; Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; end
            F2:   begin MDRout = 1'b1; IRin = 1'b1; end
            IN0:  begin Gra = 1'b1; Rin = 1'b1; inport_data_ready = 1'b1; end
            OUT0: begin Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1; end
            A0:   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            A1:   begin Cout = 1'b1; opcode = ALU_ADD; Zin = 1'b1; end
            A2:   begin Zlo_out = 1'b1; MARin = 1'b1; end
            LDI2: begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            LD3:  begin Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; MDRin = 1'b1; end
            LD4:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            ST3:  begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            ST4:  begin Mem_Write = 1'b1; Mem_enable512x32 = 1'b1; end
            default: ;
        endcase
    end
endmodule
